// File: rtl/uart_pkg.sv
// Shared UART types: parity mode, receiver FSM states and the 3-sample majority vote.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } rx_state_t;

   function automatic logic majority3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every div clocks (div 0 acts as 1), combinational tick.
// Latency: first tick div cycles after clear drops; no backpressure.
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] last;

   assign last = (div == '0) ? '0 : div - DIV_W'(1);
   assign tick = !clear && (cnt == last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear || tick)
         cnt <= '0;
      else
         cnt <= cnt + DIV_W'(1);
   end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver with majority-voted bit centres; word valid 1 clk after the last stop-bit decision.
// Backpressure: word held while !ready; a word completing meanwhile is dropped and flagged as overrun.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int      DATA_BITS = 8,
   parameter parity_t PARITY    = PAR_NONE,
   parameter int      STOP_BITS = 1,
   parameter int      OVS       = 16,
   parameter int      DIV_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 urx,
   input  logic [DIV_W-1:0]     baud_div,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int TW = $clog2(OVS);
   localparam int CW = $clog2(DATA_BITS + 1);

   rx_state_t            state, state_nx;
   logic                 sync1, urx_s, urx_d;
   logic [DIV_W-1:0]     div_q;
   logic                 tick, tick_clr;
   logic [TW-1:0]        tidx;
   logic [1:0]           samp;
   logic [CW-1:0]        bcnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr_q, ferr_q, commit;
   logic                 fall, dec, bit_v, par_exp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         urx_s <= 1'b1;
         urx_d <= 1'b1;
      end else begin
         sync1 <= urx;
         urx_s <= sync1;
         urx_d <= urx_s;
      end
   end

   assign fall    = urx_d & ~urx_s;
   assign dec     = tick && (tidx == TW'(OVS/2 + 1));
   assign bit_v   = majority3({samp, urx_s});
   assign par_exp = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;
   assign busy    = (state != ST_IDLE);

   // In BREAK the divisor only runs while the line is high, so a tick means a full high period.
   assign tick_clr = (state == ST_IDLE) || (state == ST_BREAK && !urx_s);

   uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (tick_clr),
      .div   (div_q),
      .tick  (tick)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:   if (fall) state_nx = ST_START;
         ST_START:  if (dec) state_nx = bit_v ? ST_IDLE : ST_DATA;
         ST_DATA:   if (dec && bcnt == CW'(DATA_BITS - 1))
                       state_nx = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
         ST_PARITY: if (dec) state_nx = ST_STOP;
         ST_STOP:   if (dec && bcnt == CW'(STOP_BITS - 1))
                       state_nx = bit_v ? ST_IDLE : ST_BREAK;
         ST_BREAK:  if (tick) state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // State moves at the bit decision; tidx keeps running so the next decision lands one bit later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         div_q  <= '0;
         tidx   <= '0;
         samp   <= 2'b11;
         bcnt   <= '0;
         shreg  <= '0;
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
         commit <= 1'b0;
      end else begin
         state  <= state_nx;
         commit <= 1'b0;
         if (state == ST_IDLE && fall) begin
            div_q  <= baud_div;
            bcnt   <= '0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
         end
         if (state == ST_IDLE || state == ST_BREAK)
            tidx <= '0;
         else if (tick)
            tidx <= (tidx == TW'(OVS - 1)) ? '0 : tidx + TW'(1);
         if (tick && tidx == TW'(OVS/2 - 1)) samp[0] <= urx_s;
         if (tick && tidx == TW'(OVS/2))     samp[1] <= urx_s;
         if (dec) begin
            case (state)
               ST_DATA: begin
                  shreg <= {bit_v, shreg[DATA_BITS-1:1]};
                  bcnt  <= (bcnt == CW'(DATA_BITS - 1)) ? '0 : bcnt + CW'(1);
               end
               ST_PARITY: perr_q <= bit_v ^ par_exp;
               ST_STOP: begin
                  if (!bit_v) ferr_q <= 1'b1;
                  if (bcnt == CW'(STOP_BITS - 1)) commit <= 1'b1;
                  else                            bcnt   <= bcnt + CW'(1);
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data    <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else if (commit) begin
         if (valid && !ready) begin
            overrun <= 1'b1;
         end else begin
            rx_data    <= shreg;
            parity_err <= perr_q;
            frame_err  <= ferr_q;
            valid      <= 1'b1;
            if (valid) overrun <= 1'b0;
         end
      end else if (valid && ready) begin
         valid   <= 1'b0;
         overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench: dut0 has no parity and 1 stop bit, dut1 has even parity and 2 stop bits.
`timescale 1ns/1ps
module tb_uart_rx_frame;
   import uart_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  urx;
   logic [1:0]  ready;
   logic [15:0] baud_div;

   logic [7:0] rx_data0, rx_data1;
   logic       valid0, valid1, parity_err0, parity_err1;
   logic       frame_err0, frame_err1, overrun0, overrun1, busy0, busy1;

   int n_chk = 0;
   int n_pass = 0;
   logic [9:0] sb0[$];
   logic [9:0] sb1[$];

   always #5 clk = ~clk;

   uart_rx_frame #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .OVS(16), .DIV_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .urx(urx[0]), .baud_div(baud_div),
      .rx_data(rx_data0), .valid(valid0), .ready(ready[0]),
      .parity_err(parity_err0), .frame_err(frame_err0), .overrun(overrun0), .busy(busy0));

   uart_rx_frame #(.DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(2), .OVS(16), .DIV_W(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .urx(urx[1]), .baud_div(baud_div),
      .rx_data(rx_data1), .valid(valid1), .ready(ready[1]),
      .parity_err(parity_err1), .frame_err(frame_err1), .overrun(overrun1), .busy(busy1));

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input int ln, input logic [7:0] d, input bit has_par, input logic par,
                             input int nstop, input logic stop, input int bclk);
      urx[ln] = 1'b0;
      idle(bclk);
      for (int i = 0; i < 8; i++) begin
         urx[ln] = d[i];
         idle(bclk);
      end
      if (has_par) begin
         urx[ln] = par;
         idle(bclk);
      end
      for (int i = 0; i < nstop; i++) begin
         urx[ln] = stop;
         idle(bclk);
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (rst_n && valid0 && ready[0]) begin
         check_eq("sb0_pending", 32'(sb0.size() != 0), 32'd1);
         if (sb0.size() != 0)
            check_eq("word0", 32'({frame_err0, parity_err0, rx_data0}), 32'(sb0.pop_front()));
      end
      if (rst_n && valid1 && ready[1]) begin
         check_eq("sb1_pending", 32'(sb1.size() != 0), 32'd1);
         if (sb1.size() != 0)
            check_eq("word1", 32'({frame_err1, parity_err1, rx_data1}), 32'(sb1.pop_front()));
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic       p;
      rst_n = 1'b0; urx = 2'b11; ready = 2'b11; baud_div = 16'd4;
      idle(3); #2;
      check_eq("rst_valid0", 32'(valid0), 0);
      check_eq("rst_data0", 32'(rx_data0), 0);
      check_eq("rst_flags0", 32'({parity_err0, frame_err0, overrun0, busy0}), 0);
      check_eq("rst_out1", 32'({valid1, rx_data1, parity_err1, frame_err1, overrun1, busy1}), 0);
      @(negedge clk); rst_n = 1'b1;
      idle(10);

      // basic word, then random words
      sb0.push_back({2'b00, 8'hA5});
      send_frame(0, 8'hA5, 0, 1'b0, 1, 1'b1, 64);
      idle(20);
      for (int k = 0; k < 5; k++) begin
         d = 8'($urandom_range(0, 255));
         sb0.push_back({2'b00, d});
         send_frame(0, d, 0, 1'b0, 1, 1'b1, 64);
         idle(5 + $urandom_range(0, 20));
      end

      // even parity: 0x03 has even weight, parity bit should be 0
      sb1.push_back({2'b01, 8'h03});
      send_frame(1, 8'h03, 1, 1'b1, 2, 1'b1, 64);
      idle(20);
      sb1.push_back({2'b00, 8'h03});
      send_frame(1, 8'h03, 1, 1'b0, 2, 1'b1, 64);
      idle(20);
      for (int k = 0; k < 4; k++) begin
         d = 8'($urandom_range(0, 255));
         p = 1'($urandom_range(0, 1));
         sb1.push_back({1'b0, p ^ (^d), d});
         send_frame(1, d, 1, p, 2, 1'b1, 64);
         idle(10);
      end

      // start glitch
      urx[0] = 1'b0;
      idle(5); #2;
      check_eq("glitch_busy", 32'(busy0), 1);
      idle(15);
      urx[0] = 1'b1;
      idle(44); #2;
      check_eq("glitch_idle", 32'(busy0), 0);
      check_eq("glitch_novalid", 32'(valid0), 0);
      idle(20);

      // framing error followed by a break
      sb0.push_back({2'b10, 8'hC3});
      send_frame(0, 8'hC3, 0, 1'b0, 1, 1'b0, 64);
      idle(300); #2;
      check_eq("break_busy", 32'(busy0), 1);
      @(negedge clk); urx[0] = 1'b1;
      idle(3); #2;
      check_eq("break_hold", 32'(busy0), 1);
      idle(7); #2;
      check_eq("break_exit", 32'(busy0), 0);
      idle(10);
      sb0.push_back({2'b00, 8'h5A});
      send_frame(0, 8'h5A, 0, 1'b0, 1, 1'b1, 64);
      idle(20);

      // overrun: second word dropped while first is held
      ready[0] = 1'b0;
      sb0.push_back({2'b00, 8'h11});
      send_frame(0, 8'h11, 0, 1'b0, 1, 1'b1, 64);
      send_frame(0, 8'h22, 0, 1'b0, 1, 1'b1, 64);
      idle(5); #2;
      check_eq("ovr_valid", 32'(valid0), 1);
      check_eq("ovr_data", 32'(rx_data0), 32'h11);
      check_eq("ovr_flag", 32'(overrun0), 1);
      @(negedge clk); ready[0] = 1'b1;
      @(negedge clk); ready[0] = 1'b0;
      #2;
      check_eq("ovr_clr_valid", 32'(valid0), 0);
      check_eq("ovr_clr_flag", 32'(overrun0), 0);
      @(negedge clk); ready[0] = 1'b1;
      idle(10);

      // divisor 0 behaves as 1 (16 clk per bit)
      baud_div = 16'd0;
      sb0.push_back({2'b00, 8'h96});
      send_frame(0, 8'h96, 0, 1'b0, 1, 1'b1, 16);
      idle(10);
      baud_div = 16'd4;
      idle(10);

      // divisor change mid-frame is ignored until the next frame
      sb0.push_back({2'b00, 8'h69});
      fork
         send_frame(0, 8'h69, 0, 1'b0, 1, 1'b1, 64);
         begin idle(200); baud_div = 16'd8; end
      join
      baud_div = 16'd4;
      idle(20);

      // async reset in the middle of a 0xFF frame
      urx[0] = 1'b0;
      idle(64);
      urx[0] = 1'b1;
      idle(150); #2;
      check_eq("mid_busy", 32'(busy0), 1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", 32'(busy0), 0);
      check_eq("mid_rst_out", 32'({valid0, rx_data0, parity_err0, frame_err0, overrun0}), 0);
      idle(3);
      rst_n = 1'b1;
      idle(700);

      // baud skew of about +-3%
      sb0.push_back({2'b00, 8'h3C});
      send_frame(0, 8'h3C, 0, 1'b0, 1, 1'b1, 62);
      idle(20);
      sb0.push_back({2'b00, 8'h3C});
      send_frame(0, 8'h3C, 0, 1'b0, 1, 1'b1, 66);
      idle(20);
      sb1.push_back({2'b00, 8'hE7});
      send_frame(1, 8'hE7, 1, 1'b0, 2, 1'b1, 62);
      idle(50); #2;

      check_eq("sb0_drained", 32'(sb0.size()), 0);
      check_eq("sb1_drained", 32'(sb1.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
